// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, FSM encodings, flag positions and integer saturation limits
// for the FP32 conversion blocks.
package fp32_pkg;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SHIFT  = 2'd1;
    localparam state_t ST_NEGATE = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam int FLG_INVALID = 1;
    localparam int FLG_INEXACT = 0;

    localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
    localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;
endpackage

// File: rtl/fp32_unpack.sv
// Splits an FP32 word into fields, class bits and unbiased exponent.
// Purely combinational: no latency and no flow control.
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]             data,
    output logic                    sign,
    output logic [EXP_W-1:0]        exp,
    output logic [MAN_W-1:0]        man,
    output logic                    is_nan,
    output logic                    is_inf,
    output logic                    is_zero_or_sub,
    output logic signed [EXP_W:0]   e
);
    assign sign           = data[31];
    assign exp            = data[30:23];
    assign man            = data[22:0];
    assign is_nan         = (exp == '1) && (man != '0);
    assign is_inf         = (exp == '1) && (man == '0);
    assign is_zero_or_sub = (exp == '0);
    // Nine-bit subtraction wraps correctly for the full 0..255 exponent range.
    assign e              = $signed({1'b0, exp} - 9'(EXP_BIAS));
endmodule

// File: rtl/fp32_to_int32_seq.sv
// FP32 -> int32/uint32 converter, truncating, with an iterative STEP-bit shifter.
// Latency ceil(n/STEP)+neg+1 cycles; one op in flight, in_ready only in IDLE, result held until out_ready.
module fp32_to_int32_seq
    import fp32_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_flags
);
    localparam logic [4:0] STEP_C = 5'(STEP);

    logic                  sign;
    logic [EXP_W-1:0]      exp;
    logic [MAN_W-1:0]      man;
    logic                  is_nan;
    logic                  is_inf;
    logic                  is_zero_or_sub;
    logic signed [EXP_W:0] e;

    fp32_unpack u_unpack (
        .data           (in_data),
        .sign           (sign),
        .exp            (exp),
        .man            (man),
        .is_nan         (is_nan),
        .is_inf         (is_inf),
        .is_zero_or_sub (is_zero_or_sub),
        .e              (e)
    );

    state_t      state;
    logic [31:0] sh;
    logic        sticky;
    logic [4:0]  cnt;
    logic        dir_left;
    logic        do_neg;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Results that never need the shifter.
    logic        spec_hit;
    logic [31:0] spec_data;
    logic [1:0]  spec_flags;

    always_comb begin
        spec_hit   = 1'b1;
        spec_data  = '0;
        spec_flags = '0;
        if (is_nan || is_inf) begin
            spec_flags[FLG_INVALID] = 1'b1;
            if (in_signed)
                spec_data = (is_inf && sign) ? INT32_MIN : INT32_MAX;
            else
                spec_data = (is_inf && sign) ? 32'd0 : UINT32_MAX;
        end else if (is_zero_or_sub || (exp < 8'(EXP_BIAS))) begin
            spec_flags[FLG_INEXACT] = |in_data[30:0];
        end else if (in_signed && (e >= 9'sd31)) begin
            spec_data = sign ? INT32_MIN : INT32_MAX;
            // -2^31 is the one exactly representable value at the boundary.
            spec_flags[FLG_INVALID] = !(sign && (e == 9'sd31) && (man == '0));
        end else if (!in_signed && sign) begin
            spec_flags[FLG_INVALID] = 1'b1;
        end else if (!in_signed && (e >= 9'sd32)) begin
            spec_data               = UINT32_MAX;
            spec_flags[FLG_INVALID] = 1'b1;
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic signed [EXP_W:0] e_m23;
    logic [4:0]            n;

    assign e_m23 = e - 9'sd23;
    assign n     = e_m23[EXP_W] ? 5'(-e_m23) : 5'(e_m23);

    logic [4:0]  amt;
    logic [4:0]  cnt_nxt;
    logic [31:0] sh_nxt;
    logic        sticky_nxt;
    logic [1:0]  flags_nxt;

    always_comb begin
        amt        = (cnt < STEP_C) ? cnt : STEP_C;
        cnt_nxt    = cnt - amt;
        sh_nxt     = dir_left ? (sh << amt) : (sh >> amt);
        sticky_nxt = sticky | (!dir_left && ((sh & ~(32'hFFFF_FFFF << amt)) != '0));
        flags_nxt  = '0;
        flags_nxt[FLG_INEXACT] = sticky_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sh        <= '0;
            sticky    <= 1'b0;
            cnt       <= '0;
            dir_left  <= 1'b0;
            do_neg    <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sh       <= {8'd0, 1'b1, man};
                        sticky   <= 1'b0;
                        cnt      <= n;
                        dir_left <= !e_m23[EXP_W];
                        do_neg   <= sign && in_signed;
                        if (spec_hit) begin
                            out_data  <= spec_data;
                            out_flags <= spec_flags;
                            state     <= ST_DONE;
                        end else if (n != '0) begin
                            state <= ST_SHIFT;
                        end else if (sign && in_signed) begin
                            state <= ST_NEGATE;
                        end else begin
                            out_data  <= {8'd0, 1'b1, man};
                            out_flags <= '0;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    sh     <= sh_nxt;
                    sticky <= sticky_nxt;
                    cnt    <= cnt_nxt;
                    if (cnt_nxt == '0) begin
                        if (do_neg) begin
                            state <= ST_NEGATE;
                        end else begin
                            out_data  <= sh_nxt;
                            out_flags <= flags_nxt;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_NEGATE: begin
                    out_data  <= ~sh + 32'd1;
                    out_flags <= flags_nxt;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// Self-checking bench: one converter per STEP (1,2,4,8), reference model feeds a scoreboard queue.
module tb_fp32_to_int32_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_ready;
    logic [31:0] out_data  [4];
    logic [1:0]  out_flags [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        fp32_to_int32_seq #(.STEP(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data),
            .in_signed (in_signed),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .out_data  (out_data[g]),
            .out_flags (out_flags[g])
        );
    end

    typedef struct {
        logic [31:0] data;
        logic [1:0]  flags;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Value-based reference: builds the exact integer magnitude, then clamps.
    function automatic void model(input logic [31:0] x, input bit sgn, input int step,
                                  output logic [31:0] d, output logic [1:0] f, output int lat);
        bit     s;
        bit     ninf;
        bit     inx;
        bit     neg;
        int     ex;
        int     e;
        int     n;
        longint mag;
        longint ival;
        s   = x[31];
        ex  = int'(x[30:23]);
        e   = ex - 127;
        d   = 32'd0;
        f   = 2'b00;
        lat = 1;
        inx = 1'b0;
        if (ex == 255) begin
            ninf = (x[22:0] == 23'd0) && s;
            f = 2'b10;
            if (sgn) d = ninf ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else     d = ninf ? 32'h0000_0000 : 32'hFFFF_FFFF;
            return;
        end
        if (ex == 0 || e < 0) begin
            f = {1'b0, x[30:0] != 31'd0};
            return;
        end
        mag = 64'h80_0000 | longint'(x[22:0]);
        if (e >= 40) begin
            ival = 64'h7FFF_FFFF_FFFF_FFFF;
        end else if (e >= 23) begin
            ival = mag << (e - 23);
        end else begin
            ival = mag >> (23 - e);
            inx  = (mag & ((64'd1 << (23 - e)) - 1)) != 0;
        end
        if (sgn && !s && ival >= 64'h8000_0000) begin
            d = 32'h7FFF_FFFF; f = 2'b10; return;
        end
        if (sgn && s && ival >= 64'h8000_0000) begin
            d = 32'h8000_0000; f = {ival != 64'h8000_0000, 1'b0}; return;
        end
        if (!sgn && s) begin
            f = 2'b10; return;
        end
        if (!sgn && ival >= 64'h1_0000_0000) begin
            d = 32'hFFFF_FFFF; f = 2'b10; return;
        end
        neg = sgn && s;
        n   = (e >= 23) ? e - 23 : 23 - e;
        d   = neg ? 32'(-ival) : 32'(ival);
        f   = {1'b0, inx};
        lat = (n + step - 1) / step + int'(neg) + 1;
    endfunction

    task automatic run_op(input int cur, input logic [31:0] x, input bit sgn, input bit hold);
        exp_t        ex;
        int          lat;
        logic [31:0] d0;
        logic [1:0]  f0;
        model(x, sgn, 1 << cur, ex.data, ex.flags, ex.lat);
        sb.push_back(ex);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready[cur]), 32'd1);
        in_data       = x;
        in_signed     = sgn;
        in_valid[cur] = 1'b1;
        out_ready     = !hold;
        @(posedge clk);
        #1;
        in_valid[cur] = 1'b0;
        in_data       = ~x;
        in_signed     = ~sgn;
        lat           = 1;
        @(negedge clk);
        while (out_valid[cur] !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        ex = sb.pop_front();
        if (out_valid[cur] !== 1'b1) begin
            chk("timeout", 32'(out_valid[cur]), 32'd1);
            return;
        end
        chk($sformatf("data[%h,%0d,S%0d]", x, sgn, 1 << cur), out_data[cur], ex.data);
        chk($sformatf("flags[%h,%0d,S%0d]", x, sgn, 1 << cur), 32'(out_flags[cur]), 32'(ex.flags));
        chk($sformatf("lat[%h,%0d,S%0d]", x, sgn, 1 << cur), 32'(lat), 32'(ex.lat));
        chk("in_ready_busy", 32'(in_ready[cur]), 32'd0);
        if (hold) begin
            d0 = out_data[cur];
            f0 = out_flags[cur];
            repeat (5) begin
                @(negedge clk);
                chk("hold_valid", 32'(out_valid[cur]), 32'd1);
                chk("hold_data", out_data[cur], d0);
                chk("hold_flags", 32'(out_flags[cur]), 32'(f0));
                chk("hold_in_ready", 32'(in_ready[cur]), 32'd0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("single_xfer", 32'(out_valid[cur]), 32'd0);
        chk("in_ready_after", 32'(in_ready[cur]), 32'd1);
    endtask

    logic [32:0] vec [18] = '{
        {1'b1, 32'h3F80_0000}, {1'b1, 32'hC020_0000}, {1'b0, 32'hC020_0000},
        {1'b1, 32'h4F00_0000}, {1'b1, 32'hCF00_0000}, {1'b0, 32'h4F80_0000},
        {1'b1, 32'h7FC0_0000}, {1'b1, 32'h0000_0001}, {1'b1, 32'h4B00_0001},
        {1'b1, 32'hFF80_0000}, {1'b0, 32'hFF80_0000}, {1'b0, 32'h7F80_0000},
        {1'b1, 32'h3F00_0000}, {1'b1, 32'h4EFF_FFFF}, {1'b0, 32'hBF80_0000},
        {1'b1, 32'hCB00_0001}, {1'b0, 32'h4F7F_FFFF}, {1'b1, 32'hCF00_0001}
    };

    initial begin
        int          seen;
        logic [31:0] rx;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            chk("rst_out_valid", 32'(out_valid[g]), 32'd0);
            chk("rst_out_data", out_data[g], 32'd0);
            chk("rst_out_flags", 32'(out_flags[g]), 32'd0);
            chk("rst_in_ready", 32'(in_ready[g]), 32'd1);
        end
        rst_n = 1'b1;

        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 18; i++)
                run_op(s, vec[i][31:0], vec[i][32], 1'b0);
            for (int i = 0; i < 10; i++) begin
                rx = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 162)), 23'($urandom)};
                run_op(s, rx, 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        run_op(0, 32'hC020_0000, 1'b1, 1'b1);
        run_op(3, 32'h4B00_0001, 1'b0, 1'b1);

        // Abort a STEP=4 conversion mid-shift.
        @(negedge clk);
        in_data     = 32'h3F80_0000;
        in_signed   = 1'b1;
        in_valid[2] = 1'b1;
        @(posedge clk);
        #1 in_valid[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_out_valid", 32'(out_valid[2]), 32'd0);
        chk("abort_out_data", out_data[2], 32'd0);
        chk("abort_out_flags", 32'(out_flags[2]), 32'd0);
        chk("abort_in_ready", 32'(in_ready[2]), 32'd1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid[2] === 1'b1) seen++;
        end
        chk("abort_no_emit", 32'(seen), 32'd0);
        run_op(2, 32'h3F80_0000, 1'b1, 1'b0);
        run_op(2, 32'hC020_0000, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fp32_to_int32_seq.md
Name: fp32_to_int32_seq

Overview:
- Multi-cycle converter from IEEE-754 single precision to a 32-bit integer. It performs the decode direction of the FP32 arithmetic path: it unpacks an FP32 word, aligns the significand with an iterative shifter, and emits an int32 or uint32.
- Rounding is truncation toward zero, with saturation on overflow and invalid/inexact flags.
- Sits at the output of the FP32 add/sub datapath and feeds integer consumers.
- Uses valid/ready handshakes on both sides and holds one operation in flight.

Parameters:
- STEP, 1, bits shifted per cycle in the SHIFT state; legal values are 1, 2, 4, 8.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand; high only in IDLE.
- in_data  in  32  FP32 operand {sign, exp[7:0], man[22:0]}.
- in_signed  in  1  1 = signed int32 result, 0 = unsigned uint32; sampled with in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  32  integer result.
- out_flags  out  2  [1] invalid (NaN, Inf, overflow, negative-to-unsigned), [0] inexact (nonzero bits discarded).

Behaviour:
- Reset (rst_n low at an edge): state IDLE, out_valid=0, out_data=0, out_flags=0, internal registers cleared. Reset mid-operation abandons the operation; nothing is emitted.
- in_ready = (state==IDLE). A transfer occurs when in_valid && in_ready. A transfer occurs when out_valid && out_ready.
- Decode at accept: e = exp-127. Magnitude M = {1,man} (24 bits), placed in a 32-bit shift register with a sticky bit.
- Special cases go straight to DONE, with out_valid rising 1 cycle after accept:
  - exp==255 (NaN or Inf): invalid=1. Signed gives 0x7FFFFFFF, or 0x80000000 for -Inf. Unsigned gives 0xFFFFFFFF, or 0 for -Inf.
  - exp==0 (zero or subnormal), or e<0: result 0, inexact = (in_data[30:0]!=0). Unsigned with negative nonzero input: result 0, inexact only, not invalid.
  - Signed overflow, e>=31: 0x7FFFFFFF if positive, invalid. If negative, e==31 and man==0, result is exact 0x80000000 with no flags; otherwise 0x80000000, invalid.
  - Unsigned overflow, e>=32: 0xFFFFFFFF, invalid. Unsigned negative with e>=0 (magnitude >=1): 0, invalid.
- Normal path:
  - Shift count n = |e-23|; direction is left if e>=23, right otherwise.
  - SHIFT: each cycle shifts by min(cnt, STEP) and decrements cnt by the same amount. Right shifts OR the discarded bits into sticky.
  - SHIFT is skipped when n==0.
  - When cnt reaches 0: go to NEGATE if sign && in_signed, else DONE.
  - NEGATE: one cycle; register <= two's complement.
  - inexact = sticky.
- Latency: out_valid rises ceil(n/STEP) + neg + 1 edges after the accept edge, where neg is 1 when NEGATE is taken, else 0.
- DONE: out_valid=1; out_data and out_flags are held stable until out_ready. On the handshake the state returns to IDLE and out_valid falls at the same edge. There is no accept in that same cycle; the next operand is accepted one cycle later.
- FSM states are IDLE, SHIFT, NEGATE, DONE. No other transitions exist; an illegal encoding returns to IDLE.
- Operands and in_signed are registered at accept. Changes on in_data after accept have no effect.

Decomposition:
- Shared package fp32_pkg holds:
  - EXP_BIAS=127 and the EXP_W=8, MAN_W=23 field widths.
  - The state enum {IDLE, SHIFT, NEGATE, DONE}.
  - Flag bit indices FLG_INVALID=1 and FLG_INEXACT=0.
  - Saturation constants INT32_MAX, INT32_MIN, UINT32_MAX.
- One sub-module, fp32_unpack (combinational): in_data -> sign, exp, man, is_nan, is_inf, is_zero_or_sub, unbiased e. It is reusable by the other FP32 blocks.

Test Plan:
- STEP=1, 0x3F800000 (1.0), signed, out_ready=1 -> out_data=1, flags=00, out_valid 24 cycles after accept.
- 0xC0200000 (-2.5), signed -> 0xFFFFFFFE, flags=01, latency 22+1+1=24. Same operand unsigned -> 0, flags=10.
- 0x4F000000 (2^31), signed -> 0x7FFFFFFF, flags=10, latency 1. 0xCF000000 -> 0x80000000, flags=00. 0x4F800000, unsigned -> 0xFFFFFFFF, flags=10.
- 0x7FC00000 (NaN) -> 0x7FFFFFFF, flags=10. 0x00000001 (subnormal) -> 0, flags=01. 0x4B000001 (e=23) -> 0x00800001, latency 1.
- Hold out_ready=0 for 5 cycles in DONE -> out_data, out_flags and out_valid stable; in_ready=0 throughout. Release -> one transfer only.
- Assert rst_n=0 mid-SHIFT with STEP=4 -> next cycle IDLE, out_valid=0, outputs 0. A new operand is accepted and converts correctly. Repeat the vectors above for STEP=2 and STEP=8, checking latency ceil(n/STEP).
